tl_ul_link_buffer: RTL and testbench

- Registered buffer stage for one TileLink-UL port of the E21 bus fabric.
- Sits directly upstream of the TL protocol monitor. Its A-out and D-out are the link the monitor watches.
- Decouples timing with per-channel FIFOs.
- Tracks in-flight requests and flags any D response that arrives with no outstanding A.

---
 rtl/tl_ul_link_buffer.sv | 172 +++++++++++++++++
 tb/tb_tl_ul_link_buffer.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_ul_link_buffer.sv
// tl_ul_link_buffer: registered buffer stage for one TileLink-UL port.
//   clock/reset_n   : single clock, asynchronous active-low reset
//   a_in_* / a_out_*: A channel, master side in, slave/monitor side out (A_W bits)
//   d_in_* / d_out_*: D channel, slave side in, master/monitor side out (D_W bits)
//   inflight        : A beats issued minus D beats delivered
//   err_orphan_d    : one-cycle pulse after a D beat is delivered with nothing in flight
// Optional feature macro: TL_LINK_BUFFER_PIPE_EN (accept into a full FIFO when it
// is draining in the same cycle; adds a combinational out_ready -> in_ready path).

// Generic per-channel FIFO; the parent decides when to push.
// Latency: 1 cycle push -> out_valid, no combinational in -> out path.
// Backpressure: parent must only push when count != DEPTH or a pop happens this cycle.
module tl_ul_link_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         push,
  input  logic [W-1:0]                 push_bits,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic [W-1:0]                 out_bits,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [CW-1:0] count_q;
  logic          pop;

  assign out_valid = (count_q != '0);
  assign out_bits  = mem[head_q];
  assign count     = count_q;
  assign pop       = out_valid & out_ready;

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + 1'b1;
      if (pop)  head_q <= head_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload storage needs no reset: contents are only visible while out_valid=1.
  always_ff @(posedge clock) begin
    if (push) mem[tail_q] <= push_bits;
  end

endmodule

// TileLink-UL link buffer: per-channel FIFOs plus in-flight tracking.
// Latency: 1 cycle in -> out on both A and D channels.
// Backpressure: in_ready drops when the FIFO is full; A also stalls when inflight + queued A reach MAX_INFLIGHT.
module tl_ul_link_buffer #(
  parameter int DEPTH        = 2,
  parameter int A_W          = 79,
  parameter int D_W          = 44,
  parameter int MAX_INFLIGHT = 2
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           a_in_valid,
  output logic           a_in_ready,
  input  logic [A_W-1:0] a_in_bits,
  output logic           a_out_valid,
  input  logic           a_out_ready,
  output logic [A_W-1:0] a_out_bits,
  input  logic           d_in_valid,
  output logic           d_in_ready,
  input  logic [D_W-1:0] d_in_bits,
  output logic           d_out_valid,
  input  logic           d_out_ready,
  output logic [D_W-1:0] d_out_bits,
  output logic [1:0]     inflight,
  output logic           err_orphan_d
);

  localparam int CW = $clog2(DEPTH + 1);
  // Wide enough to hold inflight + a full A FIFO without wrapping.
  localparam int SW = $clog2(MAX_INFLIGHT + DEPTH + 1) + 1;
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);
  localparam logic [1:0]    INF_MAX = 2'(MAX_INFLIGHT);

  logic [CW-1:0] a_count;
  logic [CW-1:0] d_count;
  logic          a_room;
  logic          d_room;
  logic [SW-1:0] a_reserved;
  logic          a_gate_ok;
  logic          a_push;
  logic          d_push;
  logic          a_out_fire;
  logic          d_out_fire;
  logic [1:0]    inflight_q;
  logic          err_q;

`ifdef TL_LINK_BUFFER_PIPE_EN
  // A full FIFO that is popping this cycle can take a new beat.
  assign a_room = (a_count != FULL) | a_out_ready;
  assign d_room = (d_count != FULL) | d_out_ready;
`else
  assign a_room = (a_count != FULL);
  assign d_room = (d_count != FULL);
`endif

  // Every queued or issued A beat holds a source ID until its D returns.
  assign a_reserved = SW'(inflight_q) + SW'(a_count);
  assign a_gate_ok  = (a_reserved < SW'(MAX_INFLIGHT));

  assign a_in_ready = reset_n & a_room & a_gate_ok;
  assign d_in_ready = reset_n & d_room;
  assign a_push     = a_in_valid & a_in_ready;
  assign d_push     = d_in_valid & d_in_ready;
  assign a_out_fire = a_out_valid & a_out_ready;
  assign d_out_fire = d_out_valid & d_out_ready;

  tl_ul_link_fifo #(.W(A_W), .DEPTH(DEPTH)) u_a_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (a_push),
    .push_bits (a_in_bits),
    .out_ready (a_out_ready),
    .out_valid (a_out_valid),
    .out_bits  (a_out_bits),
    .count     (a_count)
  );

  tl_ul_link_fifo #(.W(D_W), .DEPTH(DEPTH)) u_d_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (d_push),
    .push_bits (d_in_bits),
    .out_ready (d_out_ready),
    .out_valid (d_out_valid),
    .out_bits  (d_out_bits),
    .count     (d_count)
  );

  // In-flight counter saturates at both ends; an orphan D leaves it at 0
  // and raises a one-cycle error pulse instead.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= d_out_fire & (inflight_q == 2'd0);
      case ({a_out_fire, d_out_fire})
        2'b10:   if (inflight_q != INF_MAX) inflight_q <= inflight_q + 2'd1;
        2'b01:   if (inflight_q != 2'd0)    inflight_q <= inflight_q - 2'd1;
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  assign inflight     = inflight_q;
  assign err_orphan_d = err_q;

endmodule

// File: tb/tb_tl_ul_link_buffer.sv
// Directed bench for tl_ul_link_buffer: inputs driven 1 time unit after the
// rising edge, outputs sampled 1 further unit later (well clear of the edge).
module tb_tl_ul_link_buffer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        a_in_valid;
  logic        a_in_ready;
  logic [78:0] a_in_bits;
  logic        a_out_valid;
  logic        a_out_ready;
  logic [78:0] a_out_bits;
  logic        d_in_valid;
  logic        d_in_ready;
  logic [43:0] d_in_bits;
  logic        d_out_valid;
  logic        d_out_ready;
  logic [43:0] d_out_bits;
  logic [1:0]  inflight;
  logic        err_orphan_d;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  tl_ul_link_buffer dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .a_in_valid   (a_in_valid),
    .a_in_ready   (a_in_ready),
    .a_in_bits    (a_in_bits),
    .a_out_valid  (a_out_valid),
    .a_out_ready  (a_out_ready),
    .a_out_bits   (a_out_bits),
    .d_in_valid   (d_in_valid),
    .d_in_ready   (d_in_ready),
    .d_in_bits    (d_in_bits),
    .d_out_valid  (d_out_valid),
    .d_out_ready  (d_out_ready),
    .d_out_bits   (d_out_bits),
    .inflight     (inflight),
    .err_orphan_d (err_orphan_d)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [78:0] mk_a(input logic src, input logic [31:0] addr);
    // opcode=4 (Get), param=0, size=2, mask=F, data=0, corrupt=0
    return {3'd4, 3'd0, 3'd2, src, addr, 4'hF, 32'h0, 1'b0};
  endfunction

  function automatic logic [43:0] mk_d(input logic src, input logic [31:0] data);
    // opcode=1 (AccessAckData), param=0, size=2, sink=0, denied=0
    return {3'd1, 2'd0, 3'd2, src, 1'b0, 1'b0, data, 1'b0};
  endfunction

  task automatic test_reset();
    reset_n = 1'b1;
    a_in_valid = 0; a_in_bits = '0; a_out_ready = 0;
    d_in_valid = 0; d_in_bits = '0; d_out_ready = 0;
    #1 reset_n = 1'b0;
    #2;
    total++;
    if (a_out_valid !== 1'b0 || d_out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_valids a=%b d=%b exp 0 0", a_out_valid, d_out_valid);
    end
    total++;
    if (inflight !== 2'd0 || err_orphan_d !== 1'b0) begin
      bad++; $display("FAIL reset_state inflight=%0d err=%b exp 0 0", inflight, err_orphan_d);
    end
    total++;
    if (a_in_ready !== 1'b0 || d_in_ready !== 1'b0) begin
      bad++; $display("FAIL reset_ready a=%b d=%b exp 0 0", a_in_ready, d_in_ready);
    end
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    total++;
    if (a_in_ready !== 1'b1 || d_in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_release_ready a=%b d=%b exp 1 1", a_in_ready, d_in_ready);
    end
  endtask

  task automatic test_single_get();
    logic [78:0] ab;
    logic [43:0] db;
    ab = {3'd4, 3'd0, 3'd2, 1'b0, 32'h8000_0000, 4'hF, 32'h0, 1'b0};
    db = mk_d(1'b0, 32'hDEAD_BEEF);
    tick();
    a_in_valid = 1; a_in_bits = ab;
    #1;
    total++;
    if (a_out_valid !== 1'b0) begin
      bad++; $display("FAIL get_no_comb_path a_out_valid=%b exp 0", a_out_valid);
    end
    tick();
    a_in_valid = 0; a_in_bits = '0;
    #1;
    total++;
    if (a_out_valid !== 1'b1 || a_out_bits !== ab) begin
      bad++; $display("FAIL get_a_out valid=%b bits=%h exp 1 %h", a_out_valid, a_out_bits, ab);
    end
    a_out_ready = 1;
    tick();
    a_out_ready = 0;
    #1;
    total++;
    if (inflight !== 2'd1 || a_out_valid !== 1'b0) begin
      bad++; $display("FAIL get_inflight inflight=%0d a_out_valid=%b exp 1 0", inflight, a_out_valid);
    end
    d_in_valid = 1; d_in_bits = db; d_out_ready = 1;
    tick();
    d_in_valid = 0; d_in_bits = '0;
    #1;
    total++;
    if (d_out_valid !== 1'b1 || d_out_bits !== db) begin
      bad++; $display("FAIL get_d_out valid=%b bits=%h exp 1 %h", d_out_valid, d_out_bits, db);
    end
    tick();
    d_out_ready = 0;
    #1;
    total++;
    if (inflight !== 2'd0 || err_orphan_d !== 1'b0 || d_out_valid !== 1'b0) begin
      bad++; $display("FAIL get_d_done inflight=%0d err=%b dv=%b exp 0 0 0", inflight, err_orphan_d, d_out_valid);
    end
  endtask

  task automatic drain_two_d();
    d_out_ready = 1; d_in_valid = 1; d_in_bits = mk_d(1'b0, 32'h1111_0000);
    tick();
    d_in_bits = mk_d(1'b1, 32'h1111_0001);
    tick();
    d_in_valid = 0; d_in_bits = '0;
    tick();
    d_out_ready = 0;
  endtask

  task automatic test_backpressure();
    logic [78:0] b [3];
    for (int k = 0; k < 3; k++) b[k] = mk_a(k[0], 32'h1000_0000 + 32'(k * 4));
    a_out_ready = 0;
    a_in_valid = 1; a_in_bits = b[0];
    #1;
    total++;
    if (a_in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_accept0 a_in_ready=%b exp 1", a_in_ready);
    end
    tick();
    a_in_bits = b[1];
    #1;
    total++;
    if (a_in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_accept1 a_in_ready=%b exp 1", a_in_ready);
    end
    tick();
    a_in_bits = b[2];
    #1;
    total++;
    if (a_in_ready !== 1'b0 || a_out_bits !== b[0]) begin
      bad++; $display("FAIL bp_stall ready=%b bits=%h exp 0 %h", a_in_ready, a_out_bits, b[0]);
    end
    tick();
    #1;
    total++;
    if (a_out_valid !== 1'b1 || a_out_bits !== b[0] || a_in_ready !== 1'b0) begin
      bad++; $display("FAIL bp_hold valid=%b bits=%h ready=%b exp 1 %h 0", a_out_valid, a_out_bits, a_in_ready, b[0]);
    end
    a_out_ready = 1;
    tick();
    #1;
    total++;
    if (a_out_valid !== 1'b1 || a_out_bits !== b[1] || a_in_ready !== 1'b0) begin
      bad++; $display("FAIL bp_order1 valid=%b bits=%h ready=%b exp 1 %h 0", a_out_valid, a_out_bits, a_in_ready, b[1]);
    end
    tick();
    #1;
    // FIFO empty but two sources outstanding: only the inflight gate blocks.
    total++;
    if (a_out_valid !== 1'b0 || inflight !== 2'd2 || a_in_ready !== 1'b0) begin
      bad++; $display("FAIL bp_gate valid=%b inflight=%0d ready=%b exp 0 2 0", a_out_valid, inflight, a_in_ready);
    end
    a_in_valid = 0; a_in_bits = '0; a_out_ready = 0;
    drain_two_d();
    #1;
    total++;
    if (inflight !== 2'd0 || err_orphan_d !== 1'b0 || a_in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_drain inflight=%0d err=%b ready=%b exp 0 0 1", inflight, err_orphan_d, a_in_ready);
    end
  endtask

  task automatic test_orphan();
    d_in_valid = 1; d_in_bits = mk_d(1'b0, 32'h0BAD_0BAD); d_out_ready = 1;
    tick();
    d_in_valid = 0; d_in_bits = '0;
    #1;
    total++;
    if (err_orphan_d !== 1'b0) begin
      bad++; $display("FAIL orphan_early err=%b exp 0", err_orphan_d);
    end
    tick();
    #1;
    total++;
    if (err_orphan_d !== 1'b1 || inflight !== 2'd0) begin
      bad++; $display("FAIL orphan_pulse err=%b inflight=%0d exp 1 0", err_orphan_d, inflight);
    end
    tick();
    d_out_ready = 0;
    #1;
    total++;
    if (err_orphan_d !== 1'b0 || inflight !== 2'd0) begin
      bad++; $display("FAIL orphan_one_cycle err=%b inflight=%0d exp 0 0", err_orphan_d, inflight);
    end
  endtask

  task automatic test_simultaneous();
    a_in_valid = 1; a_in_bits = mk_a(1'b0, 32'h2000_0000); a_out_ready = 0;
    tick();
    a_in_valid = 0; a_out_ready = 1;
    tick();
    a_out_ready = 0;
    a_in_valid = 1; a_in_bits = mk_a(1'b1, 32'h2000_0004);
    d_in_valid = 1; d_in_bits = mk_d(1'b0, 32'h3333_3333);
    tick();
    a_in_valid = 0; a_in_bits = '0; d_in_valid = 0; d_in_bits = '0;
    #1;
    total++;
    if (inflight !== 2'd1 || a_out_valid !== 1'b1 || d_out_valid !== 1'b1) begin
      bad++; $display("FAIL simul_setup inflight=%0d av=%b dv=%b exp 1 1 1", inflight, a_out_valid, d_out_valid);
    end
    a_out_ready = 1; d_out_ready = 1;
    tick();
    a_out_ready = 0; d_out_ready = 0;
    #1;
    total++;
    if (inflight !== 2'd1 || err_orphan_d !== 1'b0) begin
      bad++; $display("FAIL simul_fire inflight=%0d err=%b exp 1 0", inflight, err_orphan_d);
    end
    d_in_valid = 1; d_in_bits = mk_d(1'b1, 32'h4444_4444); d_out_ready = 1;
    tick();
    d_in_valid = 0; d_in_bits = '0;
    tick();
    d_out_ready = 0;
    #1;
    total++;
    if (inflight !== 2'd0) begin
      bad++; $display("FAIL simul_drain inflight=%0d exp 0", inflight);
    end
  endtask

  task automatic test_d_full();
    logic [43:0] b [3];
    for (int k = 0; k < 3; k++) b[k] = mk_d(k[0], 32'h5555_0000 + 32'(k));
    d_out_ready = 0;
    d_in_valid = 1; d_in_bits = b[0];
    tick();
    d_in_bits = b[1];
    tick();
    d_in_valid = 0; d_in_bits = '0;
    #1;
    total++;
    if (d_in_ready !== 1'b0 || d_out_bits !== b[0]) begin
      bad++; $display("FAIL dfull_stall ready=%b bits=%h exp 0 %h", d_in_ready, d_out_bits, b[0]);
    end
    d_out_ready = 1;
    #1;
`ifdef TL_LINK_BUFFER_PIPE_EN
    total++;
    if (d_in_ready !== 1'b1) begin
      bad++; $display("FAIL dfull_pipe_ready ready=%b exp 1", d_in_ready);
    end
    d_in_valid = 1; d_in_bits = b[2];
    tick();
    d_in_valid = 0; d_in_bits = '0;
    #1;
    total++;
    if (d_out_bits !== b[1] || d_in_ready !== 1'b1) begin
      bad++; $display("FAIL dfull_pipe_head bits=%h ready=%b exp %h 1", d_out_bits, d_in_ready, b[1]);
    end
    tick();
    #1;
    total++;
    if (d_out_valid !== 1'b1 || d_out_bits !== b[2]) begin
      bad++; $display("FAIL dfull_pipe_tail valid=%b bits=%h exp 1 %h", d_out_valid, d_out_bits, b[2]);
    end
`else
    total++;
    if (d_in_ready !== 1'b0) begin
      bad++; $display("FAIL dfull_nopipe_ready ready=%b exp 0", d_in_ready);
    end
    tick();
    #1;
    total++;
    if (d_in_ready !== 1'b1 || d_out_valid !== 1'b1 || d_out_bits !== b[1]) begin
      bad++; $display("FAIL dfull_refill ready=%b valid=%b bits=%h exp 1 1 %h", d_in_ready, d_out_valid, d_out_bits, b[1]);
    end
`endif
    tick();
    d_out_ready = 0;
    #1;
    total++;
    if (d_out_valid !== 1'b0 || inflight !== 2'd0) begin
      bad++; $display("FAIL dfull_empty valid=%b inflight=%0d exp 0 0", d_out_valid, inflight);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    a_out_ready = 0;
    a_in_valid = 1; a_in_bits = mk_a(1'b0, 32'h6000_0000);
    tick();
    a_in_bits = mk_a(1'b1, 32'h6000_0004);
    tick();
    a_in_valid = 0; a_in_bits = '0;
    #1;
    total++;
    if (a_out_valid !== 1'b1 || a_in_ready !== 1'b0) begin
      bad++; $display("FAIL rmid_setup valid=%b ready=%b exp 1 0", a_out_valid, a_in_ready);
    end
    reset_n = 1'b0;
    #1;
    total++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b0 || inflight !== 2'd0) begin
      bad++; $display("FAIL rmid_async valid=%b ready=%b inflight=%0d exp 0 0 0", a_out_valid, a_in_ready, inflight);
    end
    tick();
    #1;
    total++;
    if (a_in_ready !== 1'b0 || d_in_ready !== 1'b0) begin
      bad++; $display("FAIL rmid_held a_ready=%b d_ready=%b exp 0 0", a_in_ready, d_in_ready);
    end
    tick();
    reset_n = 1'b1;
    #1;
    total++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
      bad++; $display("FAIL rmid_release ready=%b valid=%b exp 1 0", a_in_ready, a_out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single_get();
    test_backpressure();
    test_orphan();
    test_simultaneous();
    test_d_full();
    test_reset_mid();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
